// File: rtl/sr_drv_pkg.sv
// Shared types for the SR command driver: FSM state encoding, operation
// encoding, and the fair arbitration rule.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DRIVE_S = 2'b01,
    DRIVE_R = 2'b10,
    GAP     = 2'b11
  } state_t;

  typedef enum logic {
    OP_CLR = 1'b0,
    OP_SET = 1'b1
  } op_t;

  // When both request types are waiting, the one that did not run last wins.
  function automatic op_t pick_op(input logic want_set, input logic want_clr,
                                  input op_t last_op);
    if (want_set && want_clr) return (last_op == OP_SET) ? OP_CLR : OP_SET;
    else if (want_set)        return OP_SET;
    else                      return OP_CLR;
  endfunction

endpackage

// File: rtl/sr_cycle_timer.sv
// Loadable down-counter timing both the hold and the gap phases.
// It saturates at zero; done flags that the current phase has run out.
module sr_cycle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              value <= '0;
    else if (load)           value <= load_val;
    else if (value != '0)    value <= value - 1'b1;
  end

  assign done = (value == '0);

endmodule

// File: rtl/sr_cmd_driver.sv
// Turns set/clear request pulses into non-overlapping, timed s/r levels for
// an SR flip-flop, with one pending slot per request type.
module sr_cmd_driver
  import sr_drv_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic q_model
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state, next_state;
  op_t              last_op, launch_op;
  logic             pend_set, pend_clr, next_pset, next_pclr;
  logic             want_set, want_clr, finish;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_load_val, tmr_value;

  sr_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (tmr_value),
    .done     (tmr_done)
  );

  // A request sampled on the launching edge counts as already pending.
  assign want_set  = pend_set | set_req;
  assign want_clr  = pend_clr | clr_req;
  assign launch_op = pick_op(want_set, want_clr, last_op);
  assign finish    = ((state == DRIVE_S) || (state == DRIVE_R)) && tmr_done;

  always_comb begin
    next_state   = state;
    next_pset    = want_set;
    next_pclr    = want_clr;
    tmr_load     = 1'b0;
    tmr_load_val = HOLD_LOAD;
    case (state)
      IDLE: begin
        if (want_set || want_clr) begin
          tmr_load = 1'b1;
          if (launch_op == OP_SET) begin
            next_state = DRIVE_S;
            next_pset  = 1'b0;
          end else begin
            next_state = DRIVE_R;
            next_pclr  = 1'b0;
          end
        end
      end
      DRIVE_S, DRIVE_R: begin
        if (tmr_done) begin
          if (GAP_CYCLES == 0) begin
            next_state = IDLE;
          end else begin
            next_state   = GAP;
            tmr_load     = 1'b1;
            tmr_load_val = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (tmr_value == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode next_state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend_set <= 1'b0;
      pend_clr <= 1'b0;
      last_op  <= OP_CLR;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      q_model  <= 1'b0;
    end else begin
      state    <= next_state;
      pend_set <= next_pset;
      pend_clr <= next_pclr;
      conflict <= set_req & clr_req;
      s        <= (next_state == DRIVE_S);
      r        <= (next_state == DRIVE_R);
      busy     <= (next_state != IDLE);
      if (finish) begin
        q_model <= (state == DRIVE_S);
        last_op <= (state == DRIVE_S) ? OP_SET : OP_CLR;
      end
    end
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed scoreboard bench for sr_cmd_driver across three parameter sets,
// plus a random run checking s/r exclusivity and hold length.
module tb_sr_cmd_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] set_req = '0;
  logic [2:0] clr_req = '0;
  logic [2:0] s, r, busy, conflict, q_model;

  // dut0: defaults, dut1: long hold without gap, dut2: long hold with gap
  sr_cmd_driver #(.HOLD_CYCLES(2), .GAP_CYCLES(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .set_req(set_req[0]), .clr_req(clr_req[0]),
    .s(s[0]), .r(r[0]), .busy(busy[0]), .conflict(conflict[0]), .q_model(q_model[0]));
  sr_cmd_driver #(.HOLD_CYCLES(3), .GAP_CYCLES(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .set_req(set_req[1]), .clr_req(clr_req[1]),
    .s(s[1]), .r(r[1]), .busy(busy[1]), .conflict(conflict[1]), .q_model(q_model[1]));
  sr_cmd_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .set_req(set_req[2]), .clr_req(clr_req[2]),
    .s(s[2]), .r(r[2]), .busy(busy[2]), .conflict(conflict[2]), .q_model(q_model[2]));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: entries are {s, r, busy, conflict, q_model}
  logic [4:0] exp_q[$];
  logic [4:0] exp_v;
  int         checks = 0;
  int         errors = 0;
  int         sel = 0;
  string      tname = "reset";
  logic       rnd_on = 1'b0;
  int         run_s = 0;
  int         run_r = 0;

  function automatic logic [4:0] obs(input int idx);
    return {s[idx], r[idx], busy[idx], conflict[idx], q_model[idx]};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs(sel) !== exp_v) begin
        errors++;
        $display("FAIL %s dut%0d {s,r,busy,conflict,q}: got %b expected %b",
                 tname, sel, obs(sel), exp_v);
      end
    end
  end

  // random-phase checker on dut0 (HOLD_CYCLES=2)
  always @(negedge clk) begin
    if (rnd_on) begin
      checks++;
      if (s[0] & r[0]) begin
        errors++;
        $display("FAIL rnd_overlap: got s=%b r=%b expected not both high", s[0], r[0]);
      end
      if (s[0]) run_s++;
      else if (run_s != 0) begin
        checks++;
        if (run_s != 2) begin
          errors++;
          $display("FAIL rnd_hold_s: got %0d cycles expected 2", run_s);
        end
        run_s = 0;
      end
      if (r[0]) run_r++;
      else if (run_r != 0) begin
        checks++;
        if (run_r != 2) begin
          errors++;
          $display("FAIL rnd_hold_r: got %0d cycles expected 2", run_r);
        end
        run_r = 0;
      end
    end
  end

  // driver tasks: called just after a rising edge
  task automatic cyc(input logic sq, input logic cq, input logic [4:0] e);
    set_req[sel] = sq;
    clr_req[sel] = cq;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    set_req = '0;
    clr_req = '0;
  endtask

  // Reset is dropped just after an edge and checked before the next edge.
  task automatic do_reset(input int which);
    @(posedge clk);
    #1;
    sel = which;
    rst_n = 1'b0;
    exp_q.push_back(5'b00000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset(0);

    tname = "single_set";
    cyc(1'b1, 1'b0, 5'b10100);
    cyc(1'b0, 1'b0, 5'b10100);
    cyc(1'b0, 1'b0, 5'b00101);
    cyc(1'b0, 1'b0, 5'b00001);
    cyc(1'b0, 1'b0, 5'b00001);

    tname = "conflict";
    do_reset(0);
    cyc(1'b1, 1'b1, 5'b10110);
    cyc(1'b0, 1'b0, 5'b10100);
    cyc(1'b0, 1'b0, 5'b00101);
    cyc(1'b0, 1'b0, 5'b00001);
    cyc(1'b0, 1'b0, 5'b01101);
    cyc(1'b0, 1'b0, 5'b01101);
    cyc(1'b0, 1'b0, 5'b00100);
    cyc(1'b0, 1'b0, 5'b00000);

    tname = "merge";
    do_reset(0);
    cyc(1'b0, 1'b1, 5'b01100);
    cyc(1'b1, 1'b0, 5'b01100);
    cyc(1'b1, 1'b0, 5'b00100);
    cyc(1'b0, 1'b0, 5'b00000);
    cyc(1'b0, 1'b0, 5'b10100);
    cyc(1'b0, 1'b0, 5'b10100);
    cyc(1'b0, 1'b0, 5'b00101);
    cyc(1'b0, 1'b0, 5'b00001);
    cyc(1'b0, 1'b0, 5'b00001);
    cyc(1'b0, 1'b0, 5'b00001);

    tname = "hold3_gap0";
    do_reset(1);
    cyc(1'b1, 1'b0, 5'b10100);
    cyc(1'b0, 1'b1, 5'b10100);
    cyc(1'b0, 1'b0, 5'b10100);
    cyc(1'b0, 1'b0, 5'b00001);
    cyc(1'b0, 1'b0, 5'b01101);
    cyc(1'b0, 1'b0, 5'b01101);
    cyc(1'b0, 1'b0, 5'b01101);
    cyc(1'b0, 1'b0, 5'b00000);

    tname = "reset_mid_drive";
    do_reset(2);
    cyc(1'b1, 1'b0, 5'b10100);
    cyc(1'b0, 1'b1, 5'b10100);
    do_reset(2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 5'b00000);

    tname = "random";
    do_reset(0);
    rnd_on = 1'b1;
    for (int i = 0; i < 500; i++) begin
      set_req[0] = ($urandom_range(0, 3) == 0);
      clr_req[0] = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    set_req = '0;
    clr_req = '0;
    repeat (20) @(posedge clk);
    #1;
    rnd_on = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
